// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and helpers for the load/store sequencing controller
package lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ1,
    S_WAIT1,
    S_REQ2,
    S_WAIT2,
    S_DONE
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } lsu_size_e;

  localparam logic [3:0] BE_ALL = 4'b1111;

  // Both size strobes set is treated as a word access.
  function automatic lsu_size_e size_decode(input logic sb, input logic sh);
    case ({sb, sh})
      2'b10:   return SZ_BYTE;
      2'b01:   return SZ_HALF;
      default: return SZ_WORD;
    endcase
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] first,
                                             input logic [31:0] second,
                                             input logic [3:0]  sel_first);
    logic [31:0] res;
    res = second;
    for (int i = 0; i < 4; i++) begin
      if (sel_first[i]) res[8*i +: 8] = first[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/lsu_split_calc.sv
// rtl/lsu_split_calc.sv - decides whether an access needs a second beat and its address/byte-enables
module lsu_split_calc
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  lsu_size_e         size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        be1,
  output logic              split,
  output logic [3:0]        be2,
  output logic [ADDR_W-1:0] addr2
);

  logic [ADDR_W-3:0] word_idx;

  // Word index increments modulo the address space, so the top word wraps to 0.
  assign word_idx = addr[ADDR_W-1:2] + {{(ADDR_W-3){1'b0}}, 1'b1};
  assign addr2    = {word_idx, 2'b00};

  always_comb begin
    split = 1'b0;
    be2   = 4'b0000;
    case (size)
      SZ_WORD: begin
        split = (addr[1:0] != 2'b00);
        be2   = ~be1;
      end
      SZ_HALF: begin
        split = (addr[1:0] == 2'b11);
        be2   = 4'b0001;
      end
      default: begin
        split = 1'b0;
        be2   = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - sequences pipeline accesses into one or two word-aligned bus beats
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic              we_i,
  input  logic              sb_i,
  input  logic              sh_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [3:0]        be_i,
  input  logic [31:0]       wdata_i,
  output logic              data_req_o,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic              data_we_o,
  output logic [3:0]        data_be_o,
  output logic [31:0]       data_wdata_o,
  input  logic              data_gnt_i,
  input  logic              data_rvalid_i,
  input  logic [31:0]       data_rdata_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [31:0]       rdata_o
);

  lsu_state_e        state, state_n;
  lsu_size_e         size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be1_q;
  logic [31:0]       buf1;
  logic              split;
  logic [3:0]        be2;
  logic [ADDR_W-1:0] addr2;

  lsu_split_calc #(.ADDR_W(ADDR_W)) u_split (
    .size  (size_q),
    .addr  (addr_q),
    .be1   (be1_q),
    .split (split),
    .be2   (be2),
    .addr2 (addr2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    stall_o = 1'b0;
    done_o  = 1'b0;
    case (state)
      S_IDLE: begin
        stall_o = req_i;
        if (req_i) state_n = S_REQ1;
      end
      S_REQ1: begin
        stall_o = 1'b1;
        if (data_gnt_i) state_n = S_WAIT1;
      end
      S_WAIT1: begin
        stall_o = 1'b1;
        if (data_rvalid_i) state_n = split ? S_REQ2 : S_DONE;
      end
      S_REQ2: begin
        stall_o = 1'b1;
        if (data_gnt_i) state_n = S_WAIT2;
      end
      S_WAIT2: begin
        stall_o = 1'b1;
        if (data_rvalid_i) state_n = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Bus outputs are loaded on the edge that enters a request state and held until grant,
  // so data_gnt_i never reaches them combinationally. Beat 2 reuses we/wdata from beat 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_q       <= SZ_BYTE;
      addr_q       <= '0;
      be1_q        <= 4'b0000;
      buf1         <= 32'h0;
      rdata_o      <= 32'h0;
      data_req_o   <= 1'b0;
      data_addr_o  <= '0;
      data_we_o    <= 1'b0;
      data_be_o    <= 4'b0000;
      data_wdata_o <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_i) begin
            size_q       <= size_decode(sb_i, sh_i);
            addr_q       <= addr_i;
            be1_q        <= be_i;
            data_req_o   <= 1'b1;
            data_addr_o  <= {addr_i[ADDR_W-1:2], 2'b00};
            data_we_o    <= we_i;
            data_be_o    <= be_i;
            data_wdata_o <= wdata_i;
          end
        end
        S_REQ1, S_REQ2: begin
          if (data_gnt_i) data_req_o <= 1'b0;
        end
        S_WAIT1: begin
          if (data_rvalid_i) begin
            buf1 <= data_rdata_i;
            if (split) begin
              data_req_o  <= 1'b1;
              data_addr_o <= addr2;
              data_be_o   <= be2;
            end else begin
              rdata_o <= data_rdata_i;
            end
          end
        end
        S_WAIT2: begin
          if (data_rvalid_i) rdata_o <= lane_merge(buf1, data_rdata_i, be1_q);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - randomized self-checking bench for lsu_ctrl with a behavioural access model
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_i, we_i, sb_i, sh_i;
  logic [31:0] addr_i, wdata_i, data_addr_o, data_wdata_o, data_rdata_i, rdata_o;
  logic [3:0]  be_i, data_be_o;
  logic        data_req_o, data_we_o, data_gnt_i, data_rvalid_i, stall_o, done_o;

  int total = 0;
  int bad   = 0;

  lsu_ctrl #(.ADDR_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_i         (req_i),
    .we_i          (we_i),
    .sb_i          (sb_i),
    .sh_i          (sh_i),
    .addr_i        (addr_i),
    .be_i          (be_i),
    .wdata_i       (wdata_i),
    .data_req_o    (data_req_o),
    .data_addr_o   (data_addr_o),
    .data_we_o     (data_we_o),
    .data_be_o     (data_be_o),
    .data_wdata_o  (data_wdata_o),
    .data_gnt_i    (data_gnt_i),
    .data_rvalid_i (data_rvalid_i),
    .data_rdata_i  (data_rdata_i),
    .stall_o       (stall_o),
    .done_o        (done_o),
    .rdata_o       (rdata_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   {31'b0, data_req_o},   32'h0);
    check({tag, "_addr"},  data_addr_o,           32'h0);
    check({tag, "_we"},    {31'b0, data_we_o},    32'h0);
    check({tag, "_be"},    {28'b0, data_be_o},    32'h0);
    check({tag, "_wdata"}, data_wdata_o,          32'h0);
    check({tag, "_done"},  {31'b0, done_o},       32'h0);
    check({tag, "_rdata"}, rdata_o,               32'h0);
  endtask

  // szc = {sb, sh}. The model derives beats, merged data and completion cycle from the
  // access rules; the bench plays the bus with the given grant/response delays per beat.
  task automatic run_access(input logic we, input logic [1:0] szc, input logic [31:0] addr,
                            input logic [3:0] be, input logic [31:0] wd,
                            input int gd0, input int gd1, input int rd0, input int rd1,
                            input logic [31:0] rv0, input logic [31:0] rv1, input bit abort);
    bit          is_word, is_half, split;
    int          nb, lat, cyc, b, gcnt, rcnt;
    bit          waiting;
    int          gd[2], rd[2];
    logic [31:0] ea[2], rv[2], exp_rd;
    logic [3:0]  eb[2];

    is_word = (szc == 2'b00) || (szc == 2'b11);
    is_half = (szc == 2'b01);
    split   = (is_word && addr[1:0] != 2'b00) || (is_half && addr[1:0] == 2'b11);
    nb      = split ? 2 : 1;
    ea[0]   = addr & 32'hFFFF_FFFC;
    ea[1]   = ea[0] + 32'd4;
    eb[0]   = be;
    eb[1]   = is_word ? ~be : 4'b0001;
    gd[0] = gd0; gd[1] = gd1; rd[0] = rd0; rd[1] = rd1;
    rv[0] = rv0; rv[1] = rv1;
    for (int i = 0; i < 4; i++)
      exp_rd[8*i +: 8] = (split && !be[i]) ? rv1[8*i +: 8] : rv0[8*i +: 8];
    lat = 3 + gd0 + rd0 + (split ? 2 + gd1 + rd1 : 0);

    @(negedge clk);
    req_i = 1'b1; we_i = we; sb_i = szc[1]; sh_i = szc[0];
    addr_i = addr; be_i = be; wdata_i = wd;
    #1 check("stall_on_req", {31'b0, stall_o}, 32'h1);

    cyc = 0; b = 0; gcnt = 0; rcnt = 0; waiting = 1'b0;
    while (1) begin
      @(negedge clk);
      cyc++;
      data_gnt_i = 1'b0;
      data_rvalid_i = 1'b0;
      if (done_o) begin
        check("done_latency", cyc, lat);
        check("beats", b, nb);
        check("stall_in_done", {31'b0, stall_o}, 32'h0);
        if (!we) check("rdata", rdata_o, exp_rd);
        req_i = 1'b0;
        break;
      end
      if (cyc > 100) begin
        check("timeout", 32'h0, 32'h1);
        req_i = 1'b0;
        break;
      end
      check("stall_busy", {31'b0, stall_o}, 32'h1);
      if (!waiting) begin
        if (data_req_o) begin
          if (b >= nb) begin
            check("extra_beat", 32'h1, 32'h0);
          end else begin
            check("beat_addr",  data_addr_o,             ea[b]);
            check("beat_be",    {28'b0, data_be_o},      {28'b0, eb[b]});
            check("beat_we",    {31'b0, data_we_o},      {31'b0, we});
            check("beat_wdata", data_wdata_o,            wd);
            if (gcnt < gd[b]) gcnt++;
            else begin
              data_gnt_i = 1'b1;
              waiting = 1'b1;
              rcnt = 0;
            end
          end
        end
      end else begin
        check("req_low_in_wait", {31'b0, data_req_o}, 32'h0);
        if (abort && b == 1) begin
          rst_n = 1'b0;
          req_i = 1'b0;
          #1;
          check_reset_outputs("abort");
          check("abort_stall", {31'b0, stall_o}, 32'h0);
          @(negedge clk);
          rst_n = 1'b1;
          data_rvalid_i = 1'b1;
          data_rdata_i  = $urandom;
          for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            data_rvalid_i = 1'b0;
            check("abort_no_done", {31'b0, done_o}, 32'h0);
            check("abort_no_req",  {31'b0, data_req_o}, 32'h0);
          end
          return;
        end
        if (rcnt < rd[b]) rcnt++;
        else begin
          data_rvalid_i = 1'b1;
          data_rdata_i  = rv[b];
          b++;
          waiting = 1'b0;
          gcnt = 0;
        end
      end
    end
    @(negedge clk);
    check("idle_bubble_stall", {31'b0, stall_o}, 32'h0);
    check("idle_bubble_done",  {31'b0, done_o},  32'h0);
  endtask

  initial begin
    rst_n = 1'b0; req_i = 1'b0; we_i = 1'b0; sb_i = 1'b0; sh_i = 1'b0;
    addr_i = 32'h0; be_i = 4'h0; wdata_i = 32'h0;
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'h0;
    #12;
    check_reset_outputs("reset");
    check("reset_stall_lo", {31'b0, stall_o}, 32'h0);
    req_i = 1'b1;
    #1 check("reset_stall_hi", {31'b0, stall_o}, 32'h1);
    req_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // aligned sw, misaligned sw, split lh, grant backpressure, address wrap
    run_access(1'b1, 2'b00, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 0, 0, 0, 0, 32'h0, 32'h0, 1'b0);
    run_access(1'b1, 2'b00, 32'h0000_0101, 4'b1110, 32'hADBE_EFDE, 0, 0, 0, 0, 32'h0, 32'h0, 1'b0);
    run_access(1'b0, 2'b01, 32'h0000_0203, 4'b1000, 32'h0,        0, 0, 0, 0,
               32'h1122_3344, 32'h5566_7788, 1'b0);
    run_access(1'b1, 2'b00, 32'h0000_0100, 4'b1111, 32'hCAFE_F00D, 3, 0, 0, 0, 32'h0, 32'h0, 1'b0);
    run_access(1'b1, 2'b00, 32'hFFFF_FFFF, 4'b1000, 32'h1234_5678, 0, 0, 0, 0, 32'h0, 32'h0, 1'b0);
    run_access(1'b0, 2'b11, 32'h0000_0042, 4'b1100, 32'h0, 1, 2, 2, 1,
               $urandom, $urandom, 1'b0);

    for (int n = 0; n < 150; n++) begin
      run_access(1'($urandom), 2'($urandom), $urandom, 4'($urandom), $urandom,
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom, $urandom, 1'b0);
    end

    run_access(1'b0, 2'b00, 32'h0000_0302, 4'b1100, 32'h0, 0, 0, 0, 0,
               32'hAAAA_AAAA, 32'hBBBB_BBBB, 1'b1);
    run_access(1'b0, 2'b00, 32'h0000_0400, 4'b1111, 32'h0, 0, 0, 0, 0,
               32'h0BAD_F00D, 32'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencing controller between the core's memory stage and the data-memory bus. It accepts one access at a time from the pipeline, with byte-enables and lane-rotated write data already produced by the store-alignment logic. Accesses that cross a word boundary are split into two word-aligned bus transactions. For loads, it merges the two read beats into one raw 32-bit word, and it stalls the pipeline until the access completes.

## Interface
- ADDR_W, 32, address width (data width fixed at 32, 4 byte lanes)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_i  in  1  access request; held stable by pipeline until done_o
- we_i  in  1  1 = store, 0 = load
- sb_i, sh_i  in  1 each  byte / halfword size; both 0 = word; both 1 treated as word
- addr_i  in  ADDR_W  byte address
- be_i  in  4  first-beat byte-enables from store alignment (loads use the same encoding)
- wdata_i  in  32  lane-rotated write data
- data_req_o  out  1  bus request
- data_addr_o  out  ADDR_W  word-aligned bus address, [1:0] = 0
- data_we_o  out  1  bus write enable
- data_be_o  out  4  bus byte-enables
- data_wdata_o  out  32  bus write data
- data_gnt_i  in  1  bus grant
- data_rvalid_i  in  1  response valid; issued for loads and stores
- data_rdata_i  in  32  read data
- stall_o  out  1  pipeline hold
- done_o  out  1  one-cycle completion pulse
- rdata_o  out  32  merged raw load word; valid from done_o until the next done_o

## Operation
- FSM states: IDLE, REQ1, WAIT1, REQ2, WAIT2, DONE.
- IDLE, req_i=1:
  - Latch we, size, addr, be_i, wdata_i.
  - Compute split = (word & addr[1:0]≠0) | (half & addr[1:0]=3).
  - Go to REQ1.
- Beat 2 byte-enables: ~be1 for word; 4'b0001 for half.
- Beat 2 address: {addr[31:2]+1, 2'b00}; wraps 0xFFFFFFFC → 0x00000000.
- REQ1 / REQ2:
  - data_req_o=1 with the beat's latched addr/we/be/wdata.
  - All bus outputs are held stable until data_gnt_i.
  - On gnt, go to WAIT1 / WAIT2.
- WAIT1, rvalid: capture data_rdata_i into buf1. If split, go to REQ2; else go to DONE.
- WAIT2, rvalid: capture into buf2, go to DONE.
- DONE:
  - done_o=1, stall_o=0. req_i is ignored; the pipeline updates it at this edge.
  - Next state IDLE.
  - rdata_o is registered at entry to DONE.
- rdata_o merge:
  - Not split: buf1.
  - Split: per lane i, be1[i] ? buf1 lane : buf2 lane.
- Sign/zero extension is done downstream, not in this block.
- data_req_o is 0 outside REQ1/REQ2.
- data_rvalid_i outside WAIT1/WAIT2 is ignored.
- data_gnt_i outside REQ1/REQ2 is ignored.
- stall_o = (IDLE & req_i) | state ∈ {REQ1, WAIT1, REQ2, WAIT2}.

## Timing
- Reset (asynchronous): state=IDLE.
- Reset value 0 on every output: data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o, done_o, rdata_o. stall_o = req_i (combinational).
- Bus outputs are registered from latched state; no combinational path from data_gnt_i to bus outputs.
- Latency, accept edge at cycle T, with zero-wait bus (gnt in the first REQ cycle, rvalid in the cycle after):
  - Single beat: REQ1 at T+1, WAIT1 at T+2, DONE at T+3.
  - Split: REQ2 at T+3, WAIT2 at T+4, DONE at T+5.
- Each cycle of gnt or rvalid delay adds one cycle to completion.
- One outstanding transaction at most; no back-to-back issue; one IDLE bubble between accesses.
- Reset mid-operation: immediate return to IDLE. No done_o is issued for the aborted access. A late rvalid is ignored.

## Structure
- Shared package lsu_pkg:
  - State enum.
  - Size encoding (SZ_BYTE, SZ_HALF, SZ_WORD).
  - BE_ALL=4'b1111.
- Combinational sub-module lsu_split_calc: size + addr[1:0] + be1 + addr → split, be2, addr2.
- FSM, latches and merge stay in lsu_ctrl.

## Test plan
- Aligned store: sw 0x100, be 1111, wdata 0xDEADBEEF, zero-wait bus.
  - One beat: addr 0x100, be 1111, we=1.
  - done_o at T+3; stall_o low in that cycle.
- Misaligned store: sw 0x101, be 1110, wdata 0xADBEEFDE.
  - Beat 1: 0x100, be 1110. Beat 2: 0x104, be 0001, same wdata.
  - done_o at T+5.
- Split load: lh 0x203, be 1000, we=0; beat data 0x11223344 then 0x55667788.
  - Beats at 0x200 then 0x204, be 1000 / 0001.
  - rdata_o = 0x11667788.
- Grant backpressure: sw 0x100 with gnt low 3 cycles.
  - data_req_o, addr, be and wdata stable through the wait.
  - done_o at T+6.
- Address wrap: sw 0xFFFFFFFF, be 1000.
  - Beat 2: addr 0x00000000, be 0111.
- Reset abort: rst_n low in WAIT2, then rvalid after release.
  - All outputs 0 and state IDLE immediately.
  - No done_o pulse.
